// File: rtl/audio_pkg.sv
// Shared audio-path constants, sample/state types and a saturating counter helper.
// No logic of its own; imported by the sample stream transmitter.
package audio_pkg;

  localparam int SAMPLE_W    = 18;
  localparam int DEFAULT_DIV = 1042;
  localparam int FIFO_AW     = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO, 2^AW entries; head visible on pop_dat with zero latency.
// Push is dropped when full and pop is ignored when empty; full/empty are registered-count based.
module sample_fifo #(
  parameter int W  = 18,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sample_stream_tx.sv
// Paces buffered samples out as one new_sample strobe every DIV clocks while play=1.
// in_ready depends only on the registered FIFO count; an empty FIFO at a tick yields silence.
module sample_stream_tx #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int DIV      = audio_pkg::DEFAULT_DIV,
  parameter int FIFO_AW  = audio_pkg::FIFO_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                in_ready,
  output logic                new_sample,
  output logic [SAMPLE_W-1:0] sample,
  output logic [7:0]          underrun_count
);

  import audio_pkg::*;

  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                new_sample_q, new_sample_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [7:0]          underrun_q, underrun_d;

  logic                tick;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  assign in_ready  = reset & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign tick      = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign fifo_pop  = tick & ~fifo_empty;

  sample_fifo #(
    .W  (SAMPLE_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (fifo_push),
    .push_dat (in_sample),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The edge that first samples play=1 already counts as cycle 1 of the period,
  // so the first strobe lands exactly DIV edges later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (play) begin
          state_d = RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      RUN: begin
        if (!play) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A tick still completes when play drops on the same edge.
  always_comb begin
    new_sample_d = tick;
    sample_d     = sample_q;
    underrun_d   = underrun_q;
    if (tick) begin
      if (fifo_empty) begin
        sample_d   = '0;
        underrun_d = sat_inc8(underrun_q);
      end else begin
        sample_d = fifo_head;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      new_sample_q <= 1'b0;
      sample_q     <= '0;
      underrun_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      new_sample_q <= new_sample_d;
      sample_q     <= sample_d;
      underrun_q   <= underrun_d;
    end
  end

  assign new_sample     = new_sample_q;
  assign sample         = sample_q;
  assign underrun_count = underrun_q;

endmodule
